btn_event: RTL and testbench

Downstream consumer of the debounced button level. Classifies each press into single-cycle event pulses: press, release, short press, double click, long press, and auto-repeat while held. Sits between the debouncer output and the control FSMs and counters that act on user input. Its input is already synchronised and glitch-free, so it contains no synchroniser.

---
 rtl/btn_event.sv | 167 ++++++++++++++++
 tb/tb_btn_event.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// -----------------------------------------------------------------------------
// btn_event
//
// Classifies a debounced, already-synchronised button level into one-cycle
// event pulses for the control logic downstream: raw press/release edges,
// short press, double click, long press and auto-repeat while held.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active-high
//   btn_in         debounced button level, active-high
//   press_pulse    one-cycle pulse after a 0->1 edge of btn_in is sampled
//   release_pulse  one-cycle pulse after a 1->0 edge of btn_in is sampled
//   short_press    single press shorter than LONG_CYCLES with no second
//                  press inside DBL_WINDOW
//   double_click   second press arriving inside DBL_WINDOW
//   long_press     press held for LONG_CYCLES cycles after press_pulse
//   repeat_pulse   every REPEAT_CYCLES cycles while held after long_press
//
// All outputs are registered; none depends combinationally on btn_in.
// -----------------------------------------------------------------------------
module btn_event #(
    parameter int unsigned          CNT_WIDTH     = 24,
    parameter logic [CNT_WIDTH-1:0] LONG_CYCLES   = 24'd5_000_000,
    parameter logic [CNT_WIDTH-1:0] DBL_WINDOW    = 24'd2_500_000,
    parameter logic [CNT_WIDTH-1:0] REPEAT_CYCLES = 24'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        HOLD,
        WAIT2,
        PRESS2
    } state_t;

    // Terminal counts: cnt reads N-1 on the edge that completes N cycles
    // in the current state, because the entry edge clears it to 0.
    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = LONG_CYCLES   - CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DBL_LAST    = DBL_WINDOW    - CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = REPEAT_CYCLES - CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 btn_prev;
    logic                 rise;
    logic                 fall;
    logic                 cnt_clr;

    logic nxt_press;
    logic nxt_release;
    logic nxt_short;
    logic nxt_double;
    logic nxt_long;
    logic nxt_repeat;

    assign rise = btn_in & ~btn_prev;
    assign fall = ~btn_in & btn_prev;

    // -------------------------------------------------------------------------
    // State register, counter, edge history and registered outputs.
    // -------------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so all of them
    // update from the same pre-edge values; blocking would create ordering
    // dependencies between statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_prev      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state    <= next_state;
            btn_prev <= btn_in;

            // Cleared on every transition and on each repeat period. In the
            // states that never compare it (IDLE, PRESS2) it saturates rather
            // than wrapping during an arbitrarily long idle or hold.
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end

            press_pulse   <= nxt_press;
            release_pulse <= nxt_release;
            short_press   <= nxt_short;
            double_click  <= nxt_double;
            long_press    <= nxt_long;
            repeat_pulse  <= nxt_repeat;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    // NOTE: both combinational blocks assign defaults first so that every
    // path drives every output; a missing branch would otherwise infer a latch.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) next_state = PRESS1;
            end
            PRESS1: begin
                // Releasing on the terminal edge still counts as short.
                if (!btn_in)                next_state = WAIT2;
                else if (cnt == LONG_LAST)  next_state = HOLD;
            end
            HOLD: begin
                if (!btn_in)                  next_state = IDLE;
                else if (cnt == REPEAT_LAST)  cnt_clr    = 1'b1;
            end
            WAIT2: begin
                // A second press on the timeout edge is still a double click.
                if (rise)                   next_state = PRESS2;
                else if (cnt == DBL_LAST)   next_state = IDLE;
            end
            PRESS2: begin
                if (!btn_in) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (next_state != state) cnt_clr = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Output decode: values loaded into the output registers on this edge.
    // -------------------------------------------------------------------------
    always_comb begin
        nxt_press   = rise;
        nxt_release = fall;
        nxt_short   = 1'b0;
        nxt_double  = 1'b0;
        nxt_long    = 1'b0;
        nxt_repeat  = 1'b0;
        unique case (state)
            PRESS1: nxt_long   = btn_in && (cnt == LONG_LAST);
            HOLD:   nxt_repeat = btn_in && (cnt == REPEAT_LAST);
            WAIT2: begin
                nxt_double = rise;
                nxt_short  = !rise && (cnt == DBL_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_btn_event.sv
// -----------------------------------------------------------------------------
// tb_btn_event
//
// Table-driven bench for btn_event with LONG_CYCLES=8, DBL_WINDOW=5,
// REPEAT_CYCLES=4. Each table row gives rst/btn_in for one clock and the
// output vector expected after that clock's rising edge. The driver pushes
// the row's expectation into a scoreboard when it drives the row; a monitor
// pops and compares shortly after the following rising edge.
//
// Output vector bit order: {press, release, short, double, long, repeat}.
// -----------------------------------------------------------------------------
module tb_btn_event;

    localparam logic [5:0] M_P  = 6'b100000;
    localparam logic [5:0] M_R  = 6'b010000;
    localparam logic [5:0] M_S  = 6'b001000;
    localparam logic [5:0] M_D  = 6'b000100;
    localparam logic [5:0] M_L  = 6'b000010;
    localparam logic [5:0] M_RP = 6'b000001;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [5:0] exp;
        string      tag;
    } vec_t;

    typedef struct {
        logic [5:0] exp;
        string      tag;
    } sb_t;

    logic clk;
    logic rst;
    logic btn_in;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
    logic [5:0] outs;

    vec_t vecs[$];
    sb_t  sb[$];

    int total;
    int bad;

    btn_event #(
        .CNT_WIDTH    (24),
        .LONG_CYCLES  (24'd8),
        .DBL_WINDOW   (24'd5),
        .REPEAT_CYCLES(24'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    assign outs = {press_pulse, release_pulse, short_press,
                   double_click, long_press, repeat_pulse};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act,
                         input logic [5:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (press,rel,short,dbl,long,rep)",
                     name, act, want);
        end
    endtask

    // Append n rows of a constant level; returns the index of the first row.
    function automatic int run(input logic r, input logic b, input int n,
                               input string tag);
        int first;
        vec_t v;
        first = vecs.size();
        for (int i = 0; i < n; i++) begin
            v.rst = r;
            v.btn = b;
            v.exp = 6'b0;
            v.tag = $sformatf("%s[%0d]", tag, i);
            vecs.push_back(v);
        end
        return first;
    endfunction

    function automatic void mark(input int idx, input logic [5:0] m);
        vec_t v;
        v = vecs[idx];
        v.exp = v.exp | m;
        vecs[idx] = v;
    endfunction

    // Scoreboard consumer: outputs settle right after the rising edge that
    // sampled the row driven on the preceding falling edge.
    always begin
        sb_t e;
        @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, outs, e.exp);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, f, r2, f2;
        logic rst_q;
        sb_t  e;

        total  = 0;
        bad    = 0;
        btn_in = 1'b0;
        rst    = 1'b0;
        #1 rst = 1'b1;
        rst_q  = 1'b1;

        // Reset held while the button toggles, then released with btn_in=0.
        for (int i = 0; i < 6; i++) void'(run(1'b1, logic'(i % 2), 1, "rst_hold"));
        void'(run(1'b0, 1'b0, 4, "rst_rel"));

        // Short press: 3 cycles high; short_press 5 cycles after the fall.
        r = run(1'b0, 1'b1, 3, "short");   mark(r, M_P);
        f = run(1'b0, 1'b0, 8, "short_lo"); mark(f, M_R); mark(f + 5, M_S);

        // Long press with repeat: long at +8, repeats at +12 and +16.
        r = run(1'b0, 1'b1, 20, "long");
        mark(r, M_P); mark(r + 8, M_L); mark(r + 12, M_RP); mark(r + 16, M_RP);
        f = run(1'b0, 1'b0, 8, "long_lo"); mark(f, M_R);

        // Double click; second press held long produces nothing more.
        r  = run(1'b0, 1'b1, 2, "dbl");    mark(r, M_P);
        f  = run(1'b0, 1'b0, 2, "dbl_gap"); mark(f, M_R);
        r2 = run(1'b0, 1'b1, 20, "dbl_2"); mark(r2, M_P | M_D);
        f2 = run(1'b0, 1'b0, 8, "dbl_lo"); mark(f2, M_R);

        // Release on the long-press terminal edge: still a short press.
        r = run(1'b0, 1'b1, 8, "len8");    mark(r, M_P);
        f = run(1'b0, 1'b0, 8, "len8_lo"); mark(f, M_R); mark(f + 5, M_S);

        // One cycle longer: long press, then release with no short press.
        r = run(1'b0, 1'b1, 9, "len9");    mark(r, M_P); mark(r + 8, M_L);
        f = run(1'b0, 1'b0, 8, "len9_lo"); mark(f, M_R);

        // Second rise exactly at the window timeout edge: double click wins.
        r  = run(1'b0, 1'b1, 2, "win_edge");    mark(r, M_P);
        f  = run(1'b0, 1'b0, 5, "win_edge_gap"); mark(f, M_R);
        r2 = run(1'b0, 1'b1, 2, "win_edge_2");  mark(r2, M_P | M_D);
        f2 = run(1'b0, 1'b0, 8, "win_edge_lo"); mark(f2, M_R);

        // Second rise one cycle late: short press, then a fresh sequence.
        r  = run(1'b0, 1'b1, 2, "win_late");    mark(r, M_P);
        f  = run(1'b0, 1'b0, 6, "win_late_gap"); mark(f, M_R); mark(f + 5, M_S);
        r2 = run(1'b0, 1'b1, 3, "win_late_2");  mark(r2, M_P);
        f2 = run(1'b0, 1'b0, 8, "win_late_lo"); mark(f2, M_R); mark(f2 + 5, M_S);

        // Reset in HOLD while long_press is high; released with button held.
        r  = run(1'b0, 1'b1, 9, "midrst");      mark(r, M_P); mark(r + 8, M_L);
        void'(run(1'b1, 1'b1, 6, "midrst_rst"));
        r2 = run(1'b0, 1'b1, 13, "midrst_rel");
        mark(r2, M_P); mark(r2 + 8, M_L); mark(r2 + 12, M_RP);
        f  = run(1'b0, 1'b0, 6, "midrst_lo");   mark(f, M_R);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            btn_in = vecs[i].btn;
            e.exp  = vecs[i].exp;
            e.tag  = vecs[i].tag;
            sb.push_back(e);
            // Reset must clear outputs immediately, without waiting for clk.
            if (vecs[i].rst && !rst_q) begin
                #1 check($sformatf("async_clr[%0d]", i), outs, 6'b0);
            end
            rst_q = vecs[i].rst;
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        check("drain", {5'b0, sb.size() != 0}, 6'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
